// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port data memory arbiter.
package mem_arb_pkg;

    localparam int unsigned DEF_AW = 32;
    localparam int unsigned DEF_DW = 32;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Combinational 2-way round-robin pick; on a tie the port that did not win last time is chosen.
module rr_arb2 (
    input  logic       req0,
    input  logic       req1,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req0 && req1) begin
            gnt = last ? 2'b01 : 2'b10;
        end else if (req0) begin
            gnt = 2'b01;
        end else if (req1) begin
            gnt = 2'b10;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter/sequencer serialising requests onto the single-port data memory.
module data_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW = DEF_AW,
    parameter int unsigned DW = DEF_DW
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic          REQ0,
    input  logic          REQ1,
    input  logic          RW0,
    input  logic          RW1,
    input  logic [AW-1:0] ADDR0,
    input  logic [AW-1:0] ADDR1,
    input  logic [DW-1:0] WD0,
    input  logic [DW-1:0] WD1,
    output logic          GNT0,
    output logic          GNT1,
    output logic          RVALID0,
    output logic          RVALID1,
    output logic [DW-1:0] RDATA0,
    output logic [DW-1:0] RDATA1,
    output logic [AW-1:0] M_ADDR,
    output logic          M_RW,
    output logic [DW-1:0] M_WD,
    input  logic [DW-1:0] M_RD
);

    state_t        state;
    state_t        state_nxt;
    logic          last;
    logic [1:0]    pick;
    logic [1:0]    gnt;
    logic          lat_rw;
    logic          lat_id;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wd;
    logic [DW-1:0] rdata0_q;
    logic [DW-1:0] rdata1_q;

    rr_arb2 u_arb (
        .req0 (REQ0),
        .req1 (REQ1),
        .last (last),
        .gnt  (pick)
    );

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (REQ0 || REQ1) state_nxt = ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = (REQ0 || REQ1) ? ACCESS : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // M_RW is purely state-decoded so an asynchronous reset drops it at once.
    always_comb begin
        gnt     = 2'b00;
        RVALID0 = 1'b0;
        RVALID1 = 1'b0;
        M_RW    = 1'b0;
        unique case (state)
            IDLE: begin
                gnt = pick;
            end
            ACCESS: begin
                M_RW = (lat_rw == RW_WRITE);
            end
            RESP: begin
                gnt     = pick;
                RVALID0 = ~lat_id;
                RVALID1 = lat_id;
            end
            default: begin
                gnt = 2'b00;
            end
        endcase
    end

    assign GNT0   = gnt[0];
    assign GNT1   = gnt[1];
    assign M_ADDR = lat_addr;
    assign M_WD   = lat_wd;
    assign RDATA0 = rdata0_q;
    assign RDATA1 = rdata1_q;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            last     <= 1'b1;
            lat_rw   <= RW_READ;
            lat_id   <= 1'b0;
            lat_addr <= '0;
            lat_wd   <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            if (gnt[0] || gnt[1]) begin
                lat_id   <= gnt[1];
                last     <= gnt[1];
                lat_rw   <= gnt[1] ? RW1   : RW0;
                lat_addr <= gnt[1] ? ADDR1 : ADDR0;
                lat_wd   <= gnt[1] ? WD1   : WD0;
            end
            if (state == ACCESS && lat_rw == RW_READ) begin
                if (lat_id) begin
                    rdata1_q <= M_RD;
                end else begin
                    rdata0_q <= M_RD;
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench: directed table, hand-written corner sequences and a random phase against a transaction-level model.
module tb_data_mem_arbiter;

    logic        CLK;
    logic        RSTn;
    logic        REQ0, REQ1, RW0, RW1;
    logic [31:0] ADDR0, ADDR1, WD0, WD1;
    logic        GNT0, GNT1, RVALID0, RVALID1;
    logic [31:0] RDATA0, RDATA1, M_ADDR, M_WD, M_RD;
    logic        M_RW;

    int n_vec = 0;
    int n_err = 0;

    data_mem_arbiter #(.AW(32), .DW(32)) dut (
        .CLK     (CLK),
        .RSTn    (RSTn),
        .REQ0    (REQ0),
        .REQ1    (REQ1),
        .RW0     (RW0),
        .RW1     (RW1),
        .ADDR0   (ADDR0),
        .ADDR1   (ADDR1),
        .WD0     (WD0),
        .WD1     (WD1),
        .GNT0    (GNT0),
        .GNT1    (GNT1),
        .RVALID0 (RVALID0),
        .RVALID1 (RVALID1),
        .RDATA0  (RDATA0),
        .RDATA1  (RDATA1),
        .M_ADDR  (M_ADDR),
        .M_RW    (M_RW),
        .M_WD    (M_WD),
        .M_RD    (M_RD)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Stand-in for the data memory: 16 words, write at the edge, combinational read.
    logic [31:0] mem [16];
    logic        mem_clr;
    always @(posedge CLK) begin
        if (mem_clr) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else if (M_RW) begin
            mem[M_ADDR[5:2]] <= M_WD;
        end
    end
    assign M_RD = mem[M_ADDR[5:2]];

    logic [31:0] ref_mem [16];

    typedef struct {
        logic        req0, rw0;
        logic [31:0] addr0, wd0;
        logic        req1, rw1;
        logic [31:0] addr1, wd1;
        logic        gnt0, gnt1, rv0, rv1, mrw;
        logic [31:0] maddr, rd0, rd1;
    } vec_t;

    typedef struct {
        int          cyc;
        int          port;
        logic        rw;
        logic [31:0] data;
    } resp_t;

    localparam logic [31:0] B = 32'hDEADBEEF;
    localparam logic [31:0] C = 32'h12345678;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic g0, input logic g1,
                           input logic v0, input logic v1, input logic mrw);
        chk({tag, ".GNT0"},    32'(GNT0),    32'(g0));
        chk({tag, ".GNT1"},    32'(GNT1),    32'(g1));
        chk({tag, ".RVALID0"}, 32'(RVALID0), 32'(v0));
        chk({tag, ".RVALID1"}, 32'(RVALID1), 32'(v1));
        chk({tag, ".M_RW"},    32'(M_RW),    32'(mrw));
    endtask

    task automatic drive_idle();
        REQ0 = 1'b0; RW0 = 1'b0; ADDR0 = '0; WD0 = '0;
        REQ1 = 1'b0; RW1 = 1'b0; ADDR1 = '0; WD1 = '0;
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        tbl [11];
        resp_t       resp_q [$];
        resp_t       r;
        logic        rq [2];
        logic        rrw [2];
        logic [31:0] raddr [2];
        logic [31:0] rwd [2];
        logic [31:0] rd_m [2];
        logic [31:0] m_addr, m_wd;
        logic [1:0]  exp_rv;
        logic        acc_rw;
        int          acc_cyc, free_at, last_m, win, j;
        logic [3:0]  idx;

        //           req0 rw0  addr0   wd0    req1 rw1  addr1   wd1    g0    g1    v0    v1    mrw   maddr   rd0 rd1
        tbl[0]  = '{1'b1,1'b1,32'd8, B,     1'b0,1'b0,32'd0, 32'd0, 1'b1,1'b0,1'b0,1'b0,1'b0, 32'd0, 32'd0,32'd0};
        tbl[1]  = '{1'b0,1'b0,32'd0, 32'd0, 1'b0,1'b0,32'd0, 32'd0, 1'b0,1'b0,1'b0,1'b0,1'b1, 32'd8, 32'd0,32'd0};
        tbl[2]  = '{1'b0,1'b0,32'd0, 32'd0, 1'b1,1'b0,32'd8, 32'd0, 1'b0,1'b1,1'b1,1'b0,1'b0, 32'd8, 32'd0,32'd0};
        tbl[3]  = '{1'b0,1'b0,32'd0, 32'd0, 1'b0,1'b0,32'd0, 32'd0, 1'b0,1'b0,1'b0,1'b0,1'b0, 32'd8, 32'd0,32'd0};
        tbl[4]  = '{1'b0,1'b0,32'd0, 32'd0, 1'b0,1'b0,32'd0, 32'd0, 1'b0,1'b0,1'b0,1'b1,1'b0, 32'd8, 32'd0,B};
        tbl[5]  = '{1'b0,1'b0,32'd0, 32'd0, 1'b0,1'b0,32'd0, 32'd0, 1'b0,1'b0,1'b0,1'b0,1'b0, 32'd8, 32'd0,B};
        tbl[6]  = '{1'b1,1'b0,32'd8, 32'd0, 1'b1,1'b1,32'd12,C,     1'b1,1'b0,1'b0,1'b0,1'b0, 32'd8, 32'd0,B};
        tbl[7]  = '{1'b0,1'b0,32'd0, 32'd0, 1'b1,1'b1,32'd12,C,     1'b0,1'b0,1'b0,1'b0,1'b0, 32'd8, 32'd0,B};
        tbl[8]  = '{1'b0,1'b0,32'd0, 32'd0, 1'b1,1'b1,32'd12,C,     1'b0,1'b1,1'b1,1'b0,1'b0, 32'd8, B,    B};
        tbl[9]  = '{1'b0,1'b0,32'd0, 32'd0, 1'b0,1'b0,32'd0, 32'd0, 1'b0,1'b0,1'b0,1'b0,1'b1, 32'd12,B,    B};
        tbl[10] = '{1'b0,1'b0,32'd0, 32'd0, 1'b0,1'b0,32'd0, 32'd0, 1'b0,1'b0,1'b0,1'b1,1'b0, 32'd12,B,    B};

        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        drive_idle();
        mem_clr = 1'b1;
        RSTn    = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk_ctl("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset.M_ADDR", M_ADDR, 32'd0);
        chk("reset.M_WD",   M_WD,   32'd0);
        chk("reset.RDATA0", RDATA0, 32'd0);
        chk("reset.RDATA1", RDATA1, 32'd0);
        mem_clr = 1'b0;
        next_cycle();
        RSTn = 1'b1;

        // Write then cross-port read, then a tie resolved towards port 0.
        for (int i = 0; i < 11; i++) begin
            REQ0 = tbl[i].req0; RW0 = tbl[i].rw0; ADDR0 = tbl[i].addr0; WD0 = tbl[i].wd0;
            REQ1 = tbl[i].req1; RW1 = tbl[i].rw1; ADDR1 = tbl[i].addr1; WD1 = tbl[i].wd1;
            @(negedge CLK);
            chk_ctl($sformatf("tbl%0d", i), tbl[i].gnt0, tbl[i].gnt1, tbl[i].rv0, tbl[i].rv1, tbl[i].mrw);
            chk($sformatf("tbl%0d.M_ADDR", i), M_ADDR, tbl[i].maddr);
            chk($sformatf("tbl%0d.RDATA0", i), RDATA0, tbl[i].rd0);
            chk($sformatf("tbl%0d.RDATA1", i), RDATA1, tbl[i].rd1);
            next_cycle();
        end
        ref_mem[2] = B;
        ref_mem[3] = C;

        // Both ports held: grants alternate 0,1,0,1... one per two cycles.
        REQ0 = 1'b1; RW0 = 1'b0; ADDR0 = 32'd8;  WD0 = '0;
        REQ1 = 1'b1; RW1 = 1'b0; ADDR1 = 32'd12; WD1 = '0;
        for (int k = 0; k < 16; k++) begin
            @(negedge CLK);
            chk_ctl($sformatf("alt%0d", k), (k % 4) == 0, (k % 4) == 2,
                    (k % 4) == 2, (k > 0) && ((k % 4) == 0), 1'b0);
            next_cycle();
        end
        drive_idle();
        @(negedge CLK);
        chk_ctl("alt_end", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("alt_end.RDATA0", RDATA0, B);
        chk("alt_end.RDATA1", RDATA1, C);
        next_cycle();

        // Port 0 alone, back-to-back writes: GNT0 coincides with previous RVALID0.
        for (int k = 0; k < 9; k++) begin
            j = (k + 1) / 2;
            if (j < 4) begin
                REQ0 = 1'b1; RW0 = 1'b1; ADDR0 = 32'(16 + 4 * j); WD0 = 32'(32'hA0 + j);
            end else begin
                drive_idle();
            end
            @(negedge CLK);
            chk_ctl($sformatf("b2b%0d", k), (k % 2 == 0) && (k <= 6), 1'b0,
                    (k % 2 == 0) && (k >= 2), 1'b0, (k % 2 == 1) && (k <= 7));
            if (k % 2 == 1) begin
                chk($sformatf("b2b%0d.M_ADDR", k), M_ADDR, 32'(16 + 4 * ((k - 1) / 2)));
                chk($sformatf("b2b%0d.M_WD", k),   M_WD,   32'(32'hA0 + (k - 1) / 2));
            end
            next_cycle();
        end
        for (int i = 0; i < 4; i++) ref_mem[4 + i] = 32'(32'hA0 + i);

        // Reset during the ACCESS cycle of a write to address 4.
        REQ0 = 1'b1; RW0 = 1'b1; ADDR0 = 32'd4; WD0 = 32'h55AA55AA;
        @(negedge CLK);
        chk("rstmid.GNT0", 32'(GNT0), 32'd1);
        next_cycle();
        drive_idle();
        @(negedge CLK);
        chk("rstmid.M_RW_access", 32'(M_RW), 32'd1);
        #2;
        RSTn = 1'b0;
        #1;
        chk_ctl("rstmid.async", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rstmid.M_ADDR", M_ADDR, 32'd0);
        next_cycle();
        RSTn = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge CLK);
            chk_ctl($sformatf("rstmid.after%0d", k), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            next_cycle();
        end
        REQ0 = 1'b1; RW0 = 1'b0; ADDR0 = 32'd8;
        REQ1 = 1'b1; RW1 = 1'b0; ADDR1 = 32'd12;
        @(negedge CLK);
        chk_ctl("rstmid.tie", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        drive_idle();
        @(negedge CLK);
        next_cycle();
        @(negedge CLK);
        chk_ctl("rstmid.resp", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("rstmid.RDATA0", RDATA0, B);
        chk("rstmid.RDATA1", RDATA1, 32'd0);
        next_cycle();

        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            chk_ctl($sformatf("idle%0d", k), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            next_cycle();
        end

        // Random traffic against a transaction-level model; starts from a clean reset.
        RSTn = 1'b0;
        next_cycle();
        RSTn = 1'b1;
        free_at = 0;  last_m = 1;   acc_cyc = -1; acc_rw = 1'b0;
        m_addr  = '0; m_wd   = '0;
        for (int p = 0; p < 2; p++) begin
            rd_m[p] = '0; rq[p] = 1'b0; rrw[p] = 1'b0; raddr[p] = '0; rwd[p] = '0;
        end
        for (int c = 0; c < 404; c++) begin
            REQ0 = rq[0]; RW0 = rrw[0]; ADDR0 = raddr[0]; WD0 = rwd[0];
            REQ1 = rq[1]; RW1 = rrw[1]; ADDR1 = raddr[1]; WD1 = rwd[1];
            @(negedge CLK);
            exp_rv = '0;
            if (resp_q.size() > 0 && resp_q[0].cyc == c) begin
                r = resp_q.pop_front();
                exp_rv[r.port] = 1'b1;
                if (!r.rw) rd_m[r.port] = r.data;
            end
            win = -1;
            if (c >= free_at) begin
                if (rq[0] && rq[1])  win = (last_m == 1) ? 0 : 1;
                else if (rq[0])      win = 0;
                else if (rq[1])      win = 1;
            end
            chk_ctl($sformatf("rnd%0d", c), win == 0, win == 1, exp_rv[0], exp_rv[1],
                    (acc_cyc == c) && acc_rw);
            chk($sformatf("rnd%0d.M_ADDR", c), M_ADDR, m_addr);
            chk($sformatf("rnd%0d.M_WD", c),   M_WD,   m_wd);
            chk($sformatf("rnd%0d.RDATA0", c), RDATA0, rd_m[0]);
            chk($sformatf("rnd%0d.RDATA1", c), RDATA1, rd_m[1]);
            if (win >= 0) begin
                idx     = raddr[win][5:2];
                last_m  = win;
                free_at = c + 2;
                acc_cyc = c + 1;
                acc_rw  = rrw[win];
                m_addr  = raddr[win];
                m_wd    = rwd[win];
                r.cyc   = c + 2;
                r.port  = win;
                r.rw    = rrw[win];
                r.data  = rrw[win] ? 32'd0 : ref_mem[idx];
                if (rrw[win]) ref_mem[idx] = rwd[win];
                resp_q.push_back(r);
            end
            for (int p = 0; p < 2; p++) begin
                if (rq[p] && p != win) begin
                    if ($urandom_range(0, 15) == 0) rq[p] = 1'b0;
                end else begin
                    rq[p]    = ($urandom_range(0, 2) != 0);
                    rrw[p]   = 1'($urandom_range(0, 1));
                    raddr[p] = {26'b0, 4'($urandom_range(0, 15)), 2'b00};
                    rwd[p]   = $urandom;
                end
                if (c >= 398) rq[p] = 1'b0;
            end
            next_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-port round-robin arbiter and sequencer in front of the single-port data memory `Vr_data_mem`. It accepts read/write requests from two requesters, for example a CPU load/store unit on port 0 and a loader/DMA on port 1. It serialises the requests onto the memory's `ADDR`/`RW`/`WD`/`RD` interface and returns read data or a write acknowledge to the winning requester. It sits between the requesters and `Vr_data_mem`, and it is the only block that drives the memory.

## Interface
- `AW`, default 32: address width.
- `DW`, default 32: data width.
- `CLK`  in  1: clock; all state changes on the rising edge.
- `RSTn`  in  1: asynchronous, active-low reset.
- `REQ0`, `REQ1`  in  1: request valid; held until the matching `GNT` is sampled high.
- `RW0`, `RW1`  in  1: 0 = read, 1 = write.
- `ADDR0`, `ADDR1`  in  `AW`: request address.
- `WD0`, `WD1`  in  `DW`: write data.
- `GNT0`, `GNT1`  out  1: combinational; high in the cycle the request is accepted at the next edge.
- `RVALID0`, `RVALID1`  out  1: one-cycle completion pulse for reads and writes.
- `RDATA0`, `RDATA1`  out  `DW`: read data; valid while `RVALIDn` is high.
- `M_ADDR`  out  `AW`: address to memory `ADDR`.
- `M_RW`  out  1: to memory `RW`.
- `M_WD`  out  `DW`: to memory `WD`.
- `M_RD`  in  `DW`: from memory `RD`; combinational read data.

## Operation
- FSM states: `IDLE`, `ACCESS`, `RESP`.
- `IDLE`:
  - If any `REQ` is high: pick a winner, assert its `GNT`, latch `RW`/`ADDR`/`WD` and the winner id, go to `ACCESS`.
  - Otherwise stay in `IDLE`.
- `ACCESS` (exactly one cycle):
  - Drive `M_ADDR`/`M_WD`/`M_RW` from the latched request.
  - A write commits at the closing edge.
  - A read captures `M_RD` into the winner's `RDATA` register at the closing edge.
  - Go to `RESP`.
- `RESP`:
  - Assert `RVALID` of the latched winner.
  - Arbitrate again in the same cycle. If any `REQ` is high, grant and go to `ACCESS` (back-to-back). Otherwise go to `IDLE`.
- Arbitration:
  - Single request: it wins.
  - Both requests: the port not equal to `LAST` wins.
  - `LAST` is updated to the winner on every grant.
- Outside `ACCESS`, `M_RW` = 0 and `M_ADDR`/`M_WD` hold their latched values. No stray writes are possible.
- Writes: the `RDATAn` register is not modified.
- Register widths are exactly `AW`/`DW`. No arithmetic is performed.

## Timing
- Reset values:
  - State = `IDLE`, `LAST` = 1 (port 0 wins the first tie).
  - `GNT0`/`GNT1` = 0, `RVALID0`/`RVALID1` = 0, `M_RW` = 0.
  - `M_ADDR` = 0, `M_WD` = 0, `RDATA0`/`RDATA1` = 0.
- Latency: a grant at edge t gives `ACCESS` in cycle t+1 and `RVALID` in cycle t+2 (2 cycles from grant edge to response).
- Throughput: one transaction per 2 cycles under continuous requests.
- Alternation: with both `REQ` held high, grants alternate 0, 1, 0, 1, ...
- Request ordering: `REQn` deasserted before being granted is dropped silently.
- `GNT` rules:
  - `GNT` is never asserted in `ACCESS`.
  - At most one `GNT` is high per cycle.
  - At most one `RVALID` is high per cycle.
- Simultaneous `RVALID` (old winner) and `GNT` (new winner) in `RESP` is legal and expected.
- Reset mid-transaction:
  - The FSM returns to `IDLE` immediately and `M_RW` drops asynchronously.
  - An in-flight write may not commit.
  - No `RVALID` is issued for the aborted request.

## Structure
- Package `mem_arb_pkg` holds:
  - the state enum `IDLE`/`ACCESS`/`RESP`;
  - the `RW_READ`/`RW_WRITE` constants;
  - the default `AW`/`DW`.
- Sub-module `rr_arb2`: combinational 2-way round-robin pick from `REQ0`, `REQ1` and `LAST`, outputting a one-hot grant.
- Top level `data_mem_arbiter` holds the FSM, the request latches, `LAST` and the `RDATA` registers. `Vr_data_mem` is instantiated by the parent, not inside this block.

## Test plan
- Reset, then port 0 writes `ADDR`=8, `WD`=`0xDEADBEEF` -> `M_RW`=1 only in the `ACCESS` cycle; `RVALID0` pulses 2 cycles after `GNT0`.
- Port 1 reads `ADDR`=8 after the previous write -> `RDATA1`=`0xDEADBEEF` with `RVALID1`; `RDATA0` unchanged.
- `REQ0` and `REQ1` both held high for 8 transactions -> grant order 0,1,0,1,0,1,0,1, one `GNT` per 2 cycles.
- Back-to-back requests on port 0 alone -> `GNT0` coincides with the previous `RVALID0`, 2-cycle throughput.
- `RSTn` pulled low during `ACCESS` of a write to `ADDR`=4 -> `M_RW` goes 0 immediately, no `RVALID`, state `IDLE`, next tie goes to port 0.
- Idle for 10 cycles with no `REQ` -> `M_RW`=0 throughout, no `GNT`, no `RVALID`.
